decode_writeback: RTL and testbench
===================================

Name: decode_writeback

Overview:
- Decode/register-file stage of the sequential Y86-64 core. Sits directly downstream of instruction fetch.
- Takes icode, rA and rB from fetch, selects source and destination registers, and drives valA/valB to execute.
- On each rising clock edge, writes the execute result (valE) and the memory result (valM) back into the 15-entry register file.
- Single-cycle processor: decode reads and writeback of the same instruction happen within one clock period.

Parameters:
- STACK_BASE, 64'h0000_0000_0000_5000, reset value of %rsp (register 4).
- NREGS, 15, number of architectural registers. ID 4'hF means "no register".

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- icode  input  4  instruction class from fetch
- rA  input  4  register A field from fetch
- rB  input  4  register B field from fetch
- cnd  input  1  condition result from execute; gates the cmovq write
- instr_valid  input  1  fetch flag; 0 blocks writeback
- imem_error  input  1  fetch flag; 1 blocks writeback
- valE  input  64  execute result
- valM  input  64  memory read result
- srcA  output  4  selected source A ID
- srcB  output  4  selected source B ID
- dstE  output  4  selected E-destination ID
- dstM  output  4  selected M-destination ID
- valA  output  64  register file read data, port A
- valB  output  64  register file read data, port B
- dbg_reg  input  4  debug read select
- dbg_val  output  64  debug read data

Behaviour:
- Storage: 15 x 64-bit registers R[0..14], held in flops.
- Reset (rst_n=0, takes effect immediately, independent of clk): all registers cleared to 0, except R[4]=STACK_BASE. Outputs follow combinationally from the reset contents.
- Source selection (combinational):
  - srcA = rA for icode 2, 4, 6, A.
  - srcA = 4 for icode 9, B.
  - srcA = F otherwise.
  - srcB = rB for icode 4, 5, 6.
  - srcB = 4 for icode 8, 9, A, B.
  - srcB = F otherwise.
- Destination selection (combinational):
  - dstE = rB for icode 3 and 6.
  - dstE = rB for icode 2 only when cnd=1; dstE = F when cnd=0.
  - dstE = 4 for icode 8, 9, A, B.
  - dstE = F otherwise.
  - dstM = rA for icode 5, B.
  - dstM = F otherwise.
- Reads (combinational, zero latency):
  - valA = R[srcA]; valB = R[srcB]; dbg_val = R[dbg_reg].
  - Any read with ID F returns 0.
- Writeback enable: wb_en = instr_valid & ~imem_error & (icode != 0).
  - Halt, invalid instructions and fetch errors never modify state.
- Write (rising clk edge, when wb_en=1):
  - R[dstE] <= valE if dstE != F.
  - R[dstM] <= valM if dstM != F.
- Simultaneous write to one register (dstE == dstM, e.g. popq %rsp): valM wins.
- Read during write: reads within a cycle return the pre-edge value. There is no write-through bypass; the new value is visible after the edge.
- Unused icodes (C-F): srcA, srcB, dstE and dstM all F; no write.
- Reset asserted mid-cycle overrides any pending write. Release of rst_n is synchronous-safe: the first write occurs on the first rising edge with rst_n=1.

Test Plan:
- Reset: rst_n=0, dbg_reg sweeps 0..14 -> R4 reads 64'h5000, all other registers read 0, dbg_reg=F reads 0.
- irmovq: icode=3, rB=2, valE=64'h1234, instr_valid=1, one edge -> dstE=2 before the edge; dbg R2 = 64'h1234 after.
- OPq read-before-write: R1=5, R2=7; icode=6, rA=1, rB=2, valE=12 -> valA=5, valB=7 before the edge; R2=12 after.
- cmovq gating: icode=2, rA=1, rB=3, valE=9, cnd=0 -> dstE=F and R3 unchanged; repeat with cnd=1 -> R3=9.
- popq %rsp: icode=B, rA=4, valE=64'h5008, valM=64'hAA -> srcA=srcB=4, dstE=dstM=4; after the edge R4 = 64'hAA.
- Blocked writes: icode=3, rB=5, valE=1 with imem_error=1, then with instr_valid=0, then with icode=0 -> R5 stays 0 in all cases.
- Async reset mid-operation: write R6=77, pulse rst_n low between clock edges -> R6 reads 0 immediately, without any clock edge.

Source files
------------

// File: rtl/decode_writeback.sv
// Y86-64 decode / register-file stage: selects source and destination register IDs,
// reads valA/valB combinationally and writes valE/valM back on the rising clock edge.
module decode_writeback #(
    parameter logic [63:0] STACK_BASE = 64'h0000_0000_0000_5000,
    parameter int          NREGS      = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    input  logic [3:0]  dbg_reg,
    output logic [63:0] dbg_val
);

    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] R_RSP    = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic           wb_en;
    // Sixteen 64-bit read slots; slot 15 (and any slot beyond NREGS) is hard-wired to zero.
    logic [1023:0]  rd_flat;

    always_comb begin
        srcA = R_NONE;
        srcB = R_NONE;
        dstE = R_NONE;
        dstM = R_NONE;
        case (icode)
            I_RRMOVQ: begin
                srcA = rA;
                dstE = cnd ? rB : R_NONE;
            end
            I_IRMOVQ: dstE = rB;
            I_RMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = R_RSP;
                dstE = R_RSP;
            end
            I_RET: begin
                srcA = R_RSP;
                srcB = R_RSP;
                dstE = R_RSP;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = R_RSP;
                dstE = R_RSP;
            end
            I_POPQ: begin
                srcA = R_RSP;
                srcB = R_RSP;
                dstE = R_RSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    assign wb_en = instr_valid & ~imem_error & (icode != I_HALT);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : gen_reg
            if (gi < NREGS && gi < 15) begin : gen_live
                localparam logic [63:0] RST_VAL = (gi == 4) ? STACK_BASE : 64'h0;
                logic [63:0] val_reg;
                logic [63:0] val_next;

                // valM is checked first so a shared destination (popq %rsp) takes the memory value.
                always_comb begin
                    val_next = val_reg;
                    if (wb_en && dstM == 4'(gi))
                        val_next = valM;
                    else if (wb_en && dstE == 4'(gi))
                        val_next = valE;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        val_reg <= RST_VAL;
                    else
                        val_reg <= val_next;
                end

                assign rd_flat[gi*64 +: 64] = val_reg;
            end else begin : gen_none
                assign rd_flat[gi*64 +: 64] = 64'h0;
            end
        end
    endgenerate

    assign valA    = rd_flat[{srcA, 6'b0} +: 64];
    assign valB    = rd_flat[{srcB, 6'b0} +: 64];
    assign dbg_val = rd_flat[{dbg_reg, 6'b0} +: 64];

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: decode table, directed multi-cycle
// sequences and a randomized run against an array-based register-file model.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode, rA, rB;
    logic        cnd, instr_valid, imem_error;
    logic [63:0] valE, valM;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB;
    logic [3:0]  dbg_reg;
    logic [63:0] dbg_val;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] model [0:15];

    typedef struct {
        logic [3:0] ic;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       c;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] de;
        logic [3:0] dm;
    } vec_t;

    vec_t vecs [0:19];

    decode_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .icode       (icode),
        .rA          (rA),
        .rB          (rB),
        .cnd         (cnd),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .valE        (valE),
        .valM        (valM),
        .srcA        (srcA),
        .srcB        (srcB),
        .dstE        (dstE),
        .dstM        (dstM),
        .valA        (valA),
        .valB        (valB),
        .dbg_reg     (dbg_reg),
        .dbg_val     (dbg_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic set_in(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                          input logic c, input logic iv, input logic ie,
                          input logic [63:0] ve, input logic [63:0] vm);
        icode = ic; rA = ra; rB = rb; cnd = c;
        instr_valid = iv; imem_error = ie; valE = ve; valM = vm;
    endtask

    task automatic idle();
        set_in(4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string name, input logic [3:0] r, input logic [63:0] exp);
        dbg_reg = r;
        #1;
        chk($sformatf("%s R%0d", name, r), dbg_val, exp);
    endtask

    // Reference decode rules, written as instruction-class membership tests.
    function automatic logic [3:0] f_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_dstE(input logic [3:0] ic, input logic [3:0] rb, input logic c);
        if (ic inside {4'h3, 4'h6}) return rb;
        if (ic == 4'h2) return c ? rb : 4'hF;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_dstM(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 64'h0;
        model[4] = 64'h5000;
    endtask

    initial begin
        logic [3:0]  ic, ra, rb, dr, esa, esb, ede, edm;
        logic        c, iv, ie;
        logic [63:0] ve, vm;

        vecs[0]  = '{4'h0, 4'h7, 4'h3, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[1]  = '{4'h1, 4'h7, 4'h3, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[2]  = '{4'h2, 4'h7, 4'h3, 1'b0, 4'h7, 4'hF, 4'hF, 4'hF};
        vecs[3]  = '{4'h2, 4'h7, 4'h3, 1'b1, 4'h7, 4'hF, 4'h3, 4'hF};
        vecs[4]  = '{4'h3, 4'hF, 4'h3, 1'b0, 4'hF, 4'hF, 4'h3, 4'hF};
        vecs[5]  = '{4'h4, 4'h7, 4'h3, 1'b0, 4'h7, 4'h3, 4'hF, 4'hF};
        vecs[6]  = '{4'h5, 4'h7, 4'h3, 1'b0, 4'hF, 4'h3, 4'hF, 4'h7};
        vecs[7]  = '{4'h6, 4'h7, 4'h3, 1'b1, 4'h7, 4'h3, 4'h3, 4'hF};
        vecs[8]  = '{4'h7, 4'h7, 4'h3, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[9]  = '{4'h8, 4'h7, 4'h3, 1'b0, 4'hF, 4'h4, 4'h4, 4'hF};
        vecs[10] = '{4'h9, 4'h7, 4'h3, 1'b0, 4'h4, 4'h4, 4'h4, 4'hF};
        vecs[11] = '{4'hA, 4'h7, 4'h3, 1'b0, 4'h7, 4'h4, 4'h4, 4'hF};
        vecs[12] = '{4'hB, 4'h7, 4'h3, 1'b0, 4'h4, 4'h4, 4'h4, 4'h7};
        vecs[13] = '{4'hC, 4'h7, 4'h3, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[14] = '{4'hD, 4'h7, 4'h3, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[15] = '{4'hE, 4'h7, 4'h3, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[16] = '{4'hF, 4'h7, 4'h3, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[17] = '{4'h6, 4'hE, 4'h0, 1'b0, 4'hE, 4'h0, 4'h0, 4'hF};
        vecs[18] = '{4'h5, 4'h0, 4'hE, 1'b1, 4'hF, 4'hE, 4'hF, 4'h0};
        vecs[19] = '{4'hB, 4'h4, 4'hF, 1'b0, 4'h4, 4'h4, 4'h4, 4'h4};

        // Reset contents
        rst_n = 1'b0;
        idle();
        dbg_reg = 4'h0;
        #2;
        for (int r = 0; r < 16; r++)
            chk_reg("reset", 4'(r), (r == 4) ? 64'h5000 : 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Combinational decode table (no writes: instr_valid low, no clock edge awaited)
        for (int i = 0; i < 20; i++) begin
            set_in(vecs[i].ic, vecs[i].ra, vecs[i].rb, vecs[i].c, 1'b0, 1'b0, 64'h0, 64'h0);
            #1;
            chk($sformatf("table[%0d] srcA", i), {60'h0, srcA}, {60'h0, vecs[i].sa});
            chk($sformatf("table[%0d] srcB", i), {60'h0, srcB}, {60'h0, vecs[i].sb});
            chk($sformatf("table[%0d] dstE", i), {60'h0, dstE}, {60'h0, vecs[i].de});
            chk($sformatf("table[%0d] dstM", i), {60'h0, dstM}, {60'h0, vecs[i].dm});
            $display("table %0d icode=%h rA=%h rB=%h cnd=%0d -> srcA=%h srcB=%h dstE=%h dstM=%h",
                     i, vecs[i].ic, vecs[i].ra, vecs[i].rb, vecs[i].c, srcA, srcB, dstE, dstM);
        end
        idle();
        tick();

        // irmovq
        set_in(4'h3, 4'hF, 4'h2, 1'b0, 1'b1, 1'b0, 64'h1234, 64'h0);
        #1;
        chk("irmovq dstE", {60'h0, dstE}, 64'h2);
        tick();
        idle();
        chk_reg("irmovq", 4'h2, 64'h1234);
        $display("txn irmovq rB=2 valE=1234");

        // OPq read-before-write
        set_in(4'h3, 4'hF, 4'h1, 1'b0, 1'b1, 1'b0, 64'd5, 64'h0);
        tick();
        set_in(4'h3, 4'hF, 4'h2, 1'b0, 1'b1, 1'b0, 64'd7, 64'h0);
        tick();
        set_in(4'h6, 4'h1, 4'h2, 1'b0, 1'b1, 1'b0, 64'd12, 64'h0);
        #1;
        chk("opq valA", valA, 64'd5);
        chk("opq valB", valB, 64'd7);
        tick();
        idle();
        chk_reg("opq", 4'h2, 64'd12);
        $display("txn opq rA=1 rB=2 valE=12");

        // cmovq gating
        set_in(4'h2, 4'h1, 4'h3, 1'b0, 1'b1, 1'b0, 64'd9, 64'h0);
        #1;
        chk("cmov cnd0 dstE", {60'h0, dstE}, 64'hF);
        tick();
        idle();
        chk_reg("cmov cnd0", 4'h3, 64'h0);
        set_in(4'h2, 4'h1, 4'h3, 1'b1, 1'b1, 1'b0, 64'd9, 64'h0);
        #1;
        chk("cmov cnd1 dstE", {60'h0, dstE}, 64'h3);
        tick();
        idle();
        chk_reg("cmov cnd1", 4'h3, 64'd9);
        $display("txn cmovq rA=1 rB=3 cnd=0 then cnd=1");

        // popq %rsp: memory value wins over the stack-pointer update
        set_in(4'hB, 4'h4, 4'hF, 1'b0, 1'b1, 1'b0, 64'h5008, 64'hAA);
        #1;
        chk("popq srcA", {60'h0, srcA}, 64'h4);
        chk("popq srcB", {60'h0, srcB}, 64'h4);
        chk("popq dstE", {60'h0, dstE}, 64'h4);
        chk("popq dstM", {60'h0, dstM}, 64'h4);
        tick();
        idle();
        chk_reg("popq", 4'h4, 64'hAA);
        $display("txn popq %%rsp valE=5008 valM=AA");

        // Blocked writes
        set_in(4'h3, 4'hF, 4'h5, 1'b0, 1'b1, 1'b1, 64'd1, 64'h0);
        tick();
        idle();
        chk_reg("blocked imem_error", 4'h5, 64'h0);
        set_in(4'h3, 4'hF, 4'h5, 1'b0, 1'b0, 1'b0, 64'd1, 64'h0);
        tick();
        idle();
        chk_reg("blocked invalid", 4'h5, 64'h0);
        set_in(4'h0, 4'hF, 4'h5, 1'b0, 1'b1, 1'b0, 64'd1, 64'h0);
        tick();
        idle();
        chk_reg("blocked halt", 4'h5, 64'h0);
        $display("txn blocked writes to R5");

        // Asynchronous reset between edges
        set_in(4'h3, 4'hF, 4'h6, 1'b0, 1'b1, 1'b0, 64'd77, 64'h0);
        tick();
        idle();
        chk_reg("pre-reset", 4'h6, 64'd77);
        rst_n = 1'b0;
        chk_reg("async reset", 4'h6, 64'h0);
        chk_reg("async reset", 4'h4, 64'h5000);
        // A write pending while reset is held must be discarded
        set_in(4'h3, 4'hF, 4'h6, 1'b0, 1'b1, 1'b0, 64'd88, 64'h0);
        tick();
        chk_reg("reset held", 4'h6, 64'h0);
        rst_n = 1'b1;
        tick();
        idle();
        chk_reg("post-release", 4'h6, 64'd88);
        $display("txn async reset mid-cycle");

        // Randomized run against the model
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        tick();
        for (int t = 0; t < 300; t++) begin
            ic = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            c  = 1'($urandom_range(0, 1));
            iv = ($urandom_range(0, 7) != 0);
            ie = ($urandom_range(0, 7) == 0);
            ve = {$urandom, $urandom};
            vm = {$urandom, $urandom};
            dr = 4'($urandom_range(0, 15));
            set_in(ic, ra, rb, c, iv, ie, ve, vm);
            dbg_reg = dr;
            #1;
            esa = f_srcA(ic, ra);
            esb = f_srcB(ic, rb);
            ede = f_dstE(ic, rb, c);
            edm = f_dstM(ic, ra);
            chk($sformatf("rnd%0d srcA", t), {60'h0, srcA}, {60'h0, esa});
            chk($sformatf("rnd%0d srcB", t), {60'h0, srcB}, {60'h0, esb});
            chk($sformatf("rnd%0d dstE", t), {60'h0, dstE}, {60'h0, ede});
            chk($sformatf("rnd%0d dstM", t), {60'h0, dstM}, {60'h0, edm});
            chk($sformatf("rnd%0d valA", t), valA, model[esa]);
            chk($sformatf("rnd%0d valB", t), valB, model[esb]);
            chk($sformatf("rnd%0d dbg", t), dbg_val, model[dr]);
            $display("txn rnd %0d icode=%h rA=%h rB=%h cnd=%0d iv=%0d ie=%0d valE=%h valM=%h",
                     t, ic, ra, rb, c, iv, ie, ve, vm);
            if (iv && !ie && ic != 4'h0) begin
                if (ede != 4'hF) model[ede] = ve;
                if (edm != 4'hF) model[edm] = vm;
            end
            tick();
        end
        idle();
        for (int r = 0; r < 16; r++)
            chk_reg("final", 4'(r), model[r]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
